pc_fetch_stage: RTL
===================

# pc_fetch_stage

Instruction-fetch stage of the pipelined CPU: holds the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. It consumes the EX-stage branch offset that has already been shifted left by one (immediate << 1). It adds that offset to the branch PC to form the redirect target, then handles stall, flush and post-reset boot sequencing. It also keeps a saturating count of taken redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect (only with MISALIGN_TRAP_EN)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC and IF/ID (load-use hazard)
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_jalr  in  1  taken transfer is JALR
- ex_pc  in  32  PC of the EX-stage instruction
- ex_offset_shifted  in  32  branch/JAL immediate already shifted left by 1
- ex_jalr_target  in  32  rs1 + imm for JALR
- imem_addr  out  32  instruction-memory address (= pc)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- ifid_pc  out  32  PC of the instruction in IF/ID
- ifid_pc4  out  32  ifid_pc + 4
- ifid_instr  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- flush_idex  out  1  combinational, equals redirect; downstream squashes ID/EX
- misalign  out  1  one-cycle pulse on a trapped misaligned redirect
- redirect_count  out  16  saturating count of taken redirects

## Operation
- Target formation:
  - Non-JALR: target = ex_pc + ex_offset_shifted, modulo 2^32; wrap-around is silent.
  - JALR: target = {ex_jalr_target[31:1], 1'b0}.
- redirect = ex_branch_taken while in RUN. It is ignored in BOOT.
- FSM, 2 states:
  - BOOT: entered on reset. Lasts exactly one clock after rst deasserts. PC is held and no fetch is registered. Always transitions to RUN.
  - RUN: normal operation; stays in RUN until reset.
- Next-PC priority in RUN: redirect > stall > pc + 4. pc + 4 wraps at 2^32.
- IF/ID update in RUN:
  - On redirect (flush overrides stall): ifid_valid←0, ifid_instr←32'h0000_0013 (NOP); ifid_pc and ifid_pc4 hold.
  - Else on stall: all IF/ID fields hold.
  - Else: ifid_pc←pc, ifid_pc4←pc+4, ifid_instr←imem_rdata, ifid_valid←1.
- redirect_count increments on every cycle where redirect is asserted, and saturates at 16'hFFFF.
- Reset values: pc=RESET_PC, state=BOOT, ifid_pc=0, ifid_pc4=0, ifid_instr=32'h0000_0013, ifid_valid=0, misalign=0, redirect_count=0. flush_idex is 0 during reset and during BOOT.

## Timing
- Single clock; all registers update on the rising edge of clk. rst clears all registers immediately, independent of clk.
- Reset asserted mid-operation: all registers return to their reset values at once; state returns to BOOT.
- After rst rises:
  - Edge 1: BOOT→RUN.
  - Edge 2: first fetch from RESET_PC is registered (ifid_valid=1); pc becomes RESET_PC+4.
- Redirect latency:
  - Redirect asserted in cycle N: pc equals the target after edge N.
  - The wrong-path instruction in IF/ID is squashed at the same edge.
  - The target instruction is in IF/ID after edge N+1, provided stall is low.
- Simultaneous stall and redirect: redirect wins. PC takes the target and IF/ID is bubbled.
- stall held for k cycles: pc and IF/ID are frozen for k edges and imem_addr is stable.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A redirect whose target[1:0] != 2'b00 loads pc←TRAP_VEC instead of the target.
  - misalign is registered 1 for exactly one cycle after that edge.
  - The flush and redirect_count update still occur as for any redirect.
- MISALIGN_TRAP_EN undefined:
  - The target is loaded unchanged, including misaligned values.
  - misalign is tied to 0.

## Test plan
- Reset release with imem_rdata=32'h00A00093: BOOT one cycle, then ifid_pc=0, ifid_instr=32'h00A00093, ifid_valid=1; pc=4 on the following edge.
- Taken branch in cycle N with ex_pc=32'h40, ex_offset_shifted=32'hFFFF_FFF0: pc=32'h30 after edge N, ifid_valid=0, flush_idex=1 during N, redirect_count=1.
- stall=1 for 3 cycles at pc=32'h10: pc and IF/ID unchanged for 3 edges, then fetch resumes at 32'h10.
- stall=1 and JALR taken with ex_jalr_target=32'h0000_0123 in the same cycle: pc=32'h122, IF/ID bubbled (redirect wins over stall).
- MISALIGN_TRAP_EN defined, branch target 32'h0000_0042: pc=TRAP_VEC and misalign pulses for one cycle. Without the macro: pc=32'h42 and misalign stays 0.
- rst asserted mid-run with redirect_count=5 and ifid_valid=1: all outputs return to their reset values immediately; 65536 consecutive redirects leave redirect_count at 16'hFFFF.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage_if
//
// Bundles the fetch stage's signals: the EX-stage redirect inputs, the
// instruction-memory read port, and the IF/ID pipeline register outputs.
//
//   master : the fetch stage itself (drives imem_addr and the IF/ID outputs)
//   slave  : the surrounding pipeline and memory (drives stall, EX redirect
//            inputs and imem_rdata)
//
// Signals:
//   stall              hold PC and IF/ID (load-use hazard)
//   ex_branch_taken    EX resolved a taken branch or jump
//   ex_jalr            the taken transfer is a JALR
//   ex_pc              PC of the EX-stage instruction
//   ex_offset_shifted  branch/JAL immediate, already shifted left by one
//   ex_jalr_target     rs1 + imm for JALR
//   imem_addr          instruction-memory address (= pc)
//   imem_rdata         instruction word, combinational read of imem_addr
//   ifid_pc            PC of the instruction in IF/ID
//   ifid_pc4           ifid_pc + 4
//   ifid_instr         instruction in IF/ID
//   ifid_valid         IF/ID holds a real instruction
//   flush_idex         combinational redirect; downstream squashes ID/EX
//   misalign           one-cycle pulse on a trapped misaligned redirect
//   redirect_count     saturating count of taken redirects
// -----------------------------------------------------------------------------
interface pc_fetch_stage_if;
    logic        stall;
    logic        ex_branch_taken;
    logic        ex_jalr;
    logic [31:0] ex_pc;
    logic [31:0] ex_offset_shifted;
    logic [31:0] ex_jalr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        flush_idex;
    logic        misalign;
    logic [15:0] redirect_count;

    modport master (
        input  stall, ex_branch_taken, ex_jalr, ex_pc, ex_offset_shifted,
               ex_jalr_target, imem_rdata,
        output imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
               flush_idex, misalign, redirect_count
    );

    modport slave (
        output stall, ex_branch_taken, ex_jalr, ex_pc, ex_offset_shifted,
               ex_jalr_target, imem_rdata,
        input  imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
               flush_idex, misalign, redirect_count
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//
// Instruction-fetch stage: owns the program counter, drives the instruction
// memory address and captures the fetched word into the IF/ID register.
// A taken EX-stage branch/jump redirects the PC and bubbles IF/ID; stall
// freezes PC and IF/ID. After reset the stage spends one cycle in BOOT
// before the first fetch is registered. Taken redirects are counted with a
// 16-bit saturating counter.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   fif  pc_fetch_stage_if.master (see interface file for signal list)
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   TRAP_VEC  PC loaded on a misaligned redirect (MISALIGN_TRAP_EN only)
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect whose target is not word-aligned loads TRAP_VEC
//               and pulses misalign for one cycle
//   undefined : targets are loaded unchanged and misalign is tied low
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_stage_if.master  fif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] pc_p0,         pc_nxt;
    logic [31:0] ifid_pc_p1,    ifid_pc_nxt;
    logic [31:0] ifid_pc4_p1,   ifid_pc4_nxt;
    logic [31:0] ifid_instr_p1, ifid_instr_nxt;
    logic        vld_p1,        vld_nxt;
    logic [15:0] cnt_q,         cnt_nxt;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        trap;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Redirects are only honoured once the stage is running.
    assign redirect = fif.ex_branch_taken && (state_q == RUN);

    // JALR clears bit 0 of rs1+imm; branches/JAL add the pre-shifted offset
    // to the EX PC, wrapping silently at 2^32.
    assign target_raw = fif.ex_jalr ? (fif.ex_jalr_target & 32'hFFFF_FFFE)
                                    : (fif.ex_pc + fif.ex_offset_shifted);

`ifdef MISALIGN_TRAP_EN
    assign trap = redirect && (target_raw[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    assign target = trap ? TRAP_VEC : target_raw;

    always_comb begin
        state_d        = state_q;
        pc_nxt         = pc_p0;
        ifid_pc_nxt    = ifid_pc_p1;
        ifid_pc4_nxt   = ifid_pc4_p1;
        ifid_instr_nxt = ifid_instr_p1;
        vld_nxt        = vld_p1;
        cnt_nxt        = cnt_q;

        case (state_q)
            BOOT: begin
                // PC held, nothing fetched; the first fetch happens in RUN.
                state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
                if (redirect) begin
                    // Flush wins over stall; ifid_pc/ifid_pc4 keep their values.
                    pc_nxt         = target;
                    ifid_instr_nxt = NOP;
                    vld_nxt        = 1'b0;
                    cnt_nxt        = sat_inc16(cnt_q);
                end else if (!fif.stall) begin
                    pc_nxt         = pc_p0 + 32'd4;
                    ifid_pc_nxt    = pc_p0;
                    ifid_pc4_nxt   = pc_p0 + 32'd4;
                    ifid_instr_nxt = fif.imem_rdata;
                    vld_nxt        = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // ---- IF stage: PC / FSM / counter ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_p0   <= RESET_PC;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_p0   <= pc_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // ---- IF/ID boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_pc_p1    <= 32'd0;
            ifid_pc4_p1   <= 32'd0;
            ifid_instr_p1 <= NOP;
            vld_p1        <= 1'b0;
        end else begin
            ifid_pc_p1    <= ifid_pc_nxt;
            ifid_pc4_p1   <= ifid_pc4_nxt;
            ifid_instr_p1 <= ifid_instr_nxt;
            vld_p1        <= vld_nxt;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= trap;
        end
    end

    assign fif.misalign = misalign_q;
`else
    assign fif.misalign = 1'b0;
`endif

    assign fif.imem_addr      = pc_p0;
    assign fif.ifid_pc        = ifid_pc_p1;
    assign fif.ifid_pc4       = ifid_pc4_p1;
    assign fif.ifid_instr     = ifid_instr_p1;
    assign fif.ifid_valid     = vld_p1;
    assign fif.flush_idex     = redirect;
    assign fif.redirect_count = cnt_q;

endmodule
